uart_rx_fsm: RTL
================

// Module: uart_rx_fsm
// PURPOSE
// - UART receiver; the receive half of the full-duplex UART, paired with the 2-state transmitter.
// - Recovers 1 start bit (0), DW data bits (LSB first) and 1 stop bit (1) from serial line rx.
// - Presents each good byte on rx_data with a 1-cycle rx_valid strobe.
// - Frame errors are flagged; no internal FIFO is included.
// PARAMETERS
// - DW  8  data bits per frame (legal range 5..9)
// PORTS
// - clk        in   1   system clock, rising edge
// - rst        in   1   reset, asynchronous, active-high
// - rx         in   1   serial line, asynchronous to clk, idles high
// - clkdiv     in   8   bit period = clkdiv+1 clk cycles; legal clkdiv >= 3
// - rx_data    out  DW  last received data word
// - rx_valid   out  1   1-cycle pulse: rx_data updated with a good frame
// - frame_err  out  1   1-cycle pulse: stop bit sampled as 0
// - rx_busy    out  1   high while a frame is in progress (state != IDLE)
// - parity_err out  1   1-cycle pulse: parity mismatch (present only with UART_RX_PARITY_EN)
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; rx_data=0; rx_valid=0; frame_err=0; parity_err=0; rx_busy=0.
// - Reset also clears the counters and sets the synchronizer flops to 1.
// - rx passes through a 2-flop synchronizer (sync reset value 1); all decisions use rx_s.
// - clkdiv is latched into div_q on leaving IDLE; changes mid-frame have no effect.
// - baud_cnt counts 0..div_q, then wraps to 0.
// - The sample point is baud_cnt == div_q>>1 (mid-bit).
// - States:
//   - IDLE: rx_s==0 -> START; baud_cnt=0.
//   - START: at mid-bit, rx_s==1 -> IDLE (glitch, no outputs).
//     Otherwise clear baud_cnt, set bit_cnt=0 and go to DATA (subsequent samples land mid-bit).
//   - DATA: at each sample, shift rx_s into shreg MSB (right shift); bit_cnt++.
//     After DW samples -> PARITY if enabled, else STOP.
//   - PARITY: sample 1 bit -> STOP.
//   - STOP: at sample, rx_s==1: rx_data<=shreg and rx_valid=1 next cycle, unless a parity error occurred.
//     rx_s==0: frame_err=1 and rx_data is unchanged. Either way -> IDLE on the next cycle.
// - Break: after a frame_err, IDLE waits for rx_s==1 before re-arming start detection.
// - Latency: rx_valid rises 2 cycles (sync) + 1 cycle after the stop-bit mid-sample.
//   That is about (DW+1.5)*(clkdiv+1)+3 cycles after the start falling edge.
// - rx_valid, frame_err and parity_err are mutually exclusive and never asserted longer than 1 cycle.
// - Back-to-back frames: a start edge immediately after the stop sample is accepted (no idle gap needed).
// - rst asserted mid-frame aborts it: no rx_valid, no error pulse, rx_data=0.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: one even-parity bit follows the data.
//   - Mismatch: parity_err=1 at stop; rx_valid is suppressed; rx_data is unchanged.
// - UART_RX_PARITY_EN undefined: no PARITY state; parity_err port is tied 0.
//   - Frame is 1+DW+1 bits.
// STRUCTURE
// - Package uart_pkg:
//   - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
//   - localparam SYNC_STAGES=2
//   - localparam START_BIT=1'b0, STOP_BIT=1'b1
// - Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1.
// - Counters and FSM live in uart_rx_fsm.
// TESTING
// - clkdiv=9, send 0xA5 -> rx_data=0xA5, one rx_valid pulse, frame_err=0, rx_busy high about 95 cycles.
// - 0x3C then 0xC3 back-to-back with no idle gap, clkdiv=15 -> two rx_valid pulses, data 0x3C then 0xC3.
// - 3-cycle low glitch on idle line, clkdiv=9 -> return to IDLE, no rx_valid/frame_err, rx_busy low by sample point.
// - Frame 0x55 with stop bit forced 0 -> frame_err pulse, rx_data keeps old value.
//   - Line then held low -> no new frame until rx returns high.
// - rst pulsed mid-DATA of 0xFF -> outputs reset at once; next 0x81 is received correctly.
// - UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse, no rx_valid;
//   - With parity bit 1 -> rx_valid, rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int   SYNC_STAGES = 2;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial input.
// Resets to 1 so an idle (high) line is not mistaken for a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line through the synchronizer chain.
  // NOTE: clocked state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 1 start bit, DW data bits (LSB first), optional even parity,
// 1 stop bit. Bit period is clkdiv+1 clocks, latched at frame start.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// after the data; otherwise parity_err is tied low.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic [7:0]    clkdiv,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          rx_busy,
  output logic          parity_err
);

  localparam logic [3:0] LAST_BIT = 4'(DW - 1);

  rx_state_t     state, state_d;
  logic          rx_s;
  logic [7:0]    div_q;
  logic [7:0]    baud_cnt;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] shreg;
  logic          brk_wait;
  logic          mid_hit, bit_hit;
  logic          load_div, cnt_clr, bit_clr, shift_en, par_en, stop_ok, stop_bad;
  logic          par_bad;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // The start bit is checked half a period in; restarting the counter there
  // puts every later full-period tick in the middle of its bit.
  assign mid_hit = (baud_cnt == {1'b0, div_q[7:1]});
  assign bit_hit = (baud_cnt == div_q);
  assign rx_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d  = state;
    load_div = 1'b0;
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s == START_BIT && !brk_wait) begin
          state_d  = START;
          load_div = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      START: begin
        if (mid_hit) begin
          cnt_clr = 1'b1;
          bit_clr = 1'b1;
          state_d = (rx_s == STOP_BIT) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_hit) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_hit) begin
          par_en  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_hit) begin
          state_d = IDLE;
          if (rx_s == STOP_BIT) stop_ok  = 1'b1;
          else                  stop_bad = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud counter, divisor latch and data bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      div_q    <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load_div) div_q <= clkdiv;
      if (state == IDLE || cnt_clr || bit_hit) baud_cnt <= '0;
      else                                     baud_cnt <= baud_cnt + 8'd1;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Data shift register (LSB arrives first, so shift right into the MSB).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           shreg <= '0;
    else if (shift_en) shreg <= {rx_s, shreg[DW-1:1]};
  end

  // Break handling: after a bad stop bit, ignore the low line until it idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     brk_wait <= 1'b0;
    else if (stop_bad)                           brk_wait <= 1'b1;
    else if (state == IDLE && rx_s == STOP_BIT)  brk_wait <= 1'b0;
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits plus the parity bit must XOR to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_bad <= 1'b0;
    else if (par_en) par_bad <= (^shreg) ^ rx_s;
  end
`else
  assign par_bad = 1'b0;
`endif

  // Result registers and single-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid   <= stop_ok && !par_bad;
      frame_err  <= stop_bad;
      parity_err <= stop_ok && par_bad;
      if (stop_ok && !par_bad) rx_data <= shreg;
    end
  end

endmodule
